pmp_multi: RTL and testbench

PMP_MULTI -- requirements
Module: pmp_multi

---
 rtl/pmp_multi.sv | 135 +++++++++++++
 tb/tb_pmp_multi.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_multi.sv
// Physical memory protection table shared by NCH parallel check channels.
// Table writes and per-channel permission responses are registered on i_clk.
module pmp_multi #(
    parameter  int ADDR_BITS = 48,
    parameter  int TBL_SIZE  = 16,
    parameter  int NCH       = 2,
    localparam int IW        = (TBL_SIZE > 1) ? $clog2(TBL_SIZE) : 1,
    localparam int AW        = ADDR_BITS - 2
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_we,
    input  logic [IW-1:0]          i_wr_idx,
    input  logic [7:0]             i_wr_cfg,
    input  logic [AW-1:0]          i_wr_addr,
    input  logic [IW-1:0]          i_rd_idx,
    output logic [7:0]             o_rd_cfg,
    output logic [AW-1:0]          o_rd_addr,
    input  logic [NCH-1:0]         i_req_valid,
    input  logic [NCH*ADDR_BITS-1:0] i_req_addr,
    input  logic [NCH-1:0]         i_req_m,
    output logic [NCH-1:0]         o_resp_valid,
    output logic [NCH*3-1:0]       o_resp_rwx,
    output logic [NCH-1:0]         o_resp_hit,
    output logic [NCH*IW-1:0]      o_resp_idx
);

    logic [7:0]          cfg_q    [TBL_SIZE];
    logic [AW-1:0]       addr_q   [TBL_SIZE];
    logic [AW-1:0]       lo_bound [TBL_SIZE];
    logic [TBL_SIZE-1:0] tor_locked;

    logic [2:0]          rwx_c [NCH];
    logic                hit_c [NCH];
    logic [IW-1:0]       idx_c [NCH];

    logic [NCH-1:0]      vld_p1;
    logic [NCH*3-1:0]    rwx_p1;
    logic [NCH-1:0]      hit_p1;
    logic [NCH*IW-1:0]   idx_p1;

    logic                unused_cfg_bits;
    assign unused_cfg_bits = ^i_wr_cfg[6:5];

    // Reserved bits read as zero; write-without-read is not a legal combination.
    function automatic logic [7:0] legalize_cfg(input logic [7:0] c);
        return {c[7], 2'b00, c[4:2], c[1] & c[0], c[0]};
    endfunction

    function automatic logic entry_match(input logic [7:0] c, input logic [AW-1:0] pa,
                                         input logic [AW-1:0] lo, input logic [ADDR_BITS-1:0] a);
        logic [AW-1:0] keep;
        // Trailing ones plus the first zero form the don't-care field of a NAPOT region.
        keep = ~(pa ^ (pa + AW'(1)));
        case (c[4:3])
            2'b01:   entry_match = (a >= {lo, 2'b00}) && (a < {pa, 2'b00});
            2'b10:   entry_match = (a[ADDR_BITS-1:2] == pa);
            2'b11:   entry_match = ((a[ADDR_BITS-1:2] ^ pa) & keep) == '0;
            default: entry_match = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] perm(input logic [7:0] c, input logic m);
        return (m && !c[7]) ? 3'b111 : {c[0], c[1], c[2]};
    endfunction

    always_comb begin
        tor_locked  = '0;
        lo_bound[0] = '0;
        for (int i = 1; i < TBL_SIZE; i++) begin
            lo_bound[i]     = addr_q[i-1];
            tor_locked[i-1] = cfg_q[i][7] && (cfg_q[i][4:3] == 2'b01);
        end
    end

    // Descending scan so the lowest matching index is the last assignment.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            hit_c[c] = 1'b0;
            idx_c[c] = '0;
            rwx_c[c] = i_req_m[c] ? 3'b111 : 3'b000;
            for (int i = TBL_SIZE - 1; i >= 0; i--) begin
                if (entry_match(cfg_q[i], addr_q[i], lo_bound[i], i_req_addr[c*ADDR_BITS +: ADDR_BITS])) begin
                    hit_c[c] = 1'b1;
                    idx_c[c] = IW'(i);
                    rwx_c[c] = perm(cfg_q[i], i_req_m[c]);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int i = 0; i < TBL_SIZE; i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < TBL_SIZE; i++) begin
                if ((i_wr_idx == IW'(i)) && !cfg_q[i][7]) begin
                    cfg_q[i] <= legalize_cfg(i_wr_cfg);
                    if (!tor_locked[i])
                        addr_q[i] <= i_wr_addr;
                end
            end
        end
    end

    // Stage p1: registered response, results hold when no request was sampled.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            vld_p1 <= '0;
            rwx_p1 <= '0;
            hit_p1 <= '0;
            idx_p1 <= '0;
        end else begin
            vld_p1 <= i_req_valid;
            for (int c = 0; c < NCH; c++) begin
                if (i_req_valid[c]) begin
                    rwx_p1[c*3 +: 3]   <= rwx_c[c];
                    hit_p1[c]          <= hit_c[c];
                    idx_p1[c*IW +: IW] <= idx_c[c];
                end
            end
        end
    end

    assign o_rd_cfg     = (int'(i_rd_idx) < TBL_SIZE) ? cfg_q[i_rd_idx]  : '0;
    assign o_rd_addr    = (int'(i_rd_idx) < TBL_SIZE) ? addr_q[i_rd_idx] : '0;
    assign o_resp_valid = vld_p1;
    assign o_resp_rwx   = rwx_p1;
    assign o_resp_hit   = hit_p1;
    assign o_resp_idx   = idx_p1;

endmodule

// File: tb/tb_pmp_multi.sv
// Bench for pmp_multi: directed scenarios plus randomized traffic checked
// against a range-based reference model of the PMP table.
module tb_pmp_multi;
    localparam int AB = 48, TS = 16, NC = 2, IW = 4, AW = 46;

    logic clk = 1'b0, nrst = 1'b0;
    always #5 clk = ~clk;

    logic           we;
    logic [IW-1:0]  wr_idx, rd_idx;
    logic [7:0]     wr_cfg, rd_cfg;
    logic [AW-1:0]  wr_addr, rd_addr;
    logic [NC-1:0]  req_valid, req_m, resp_valid, resp_hit;
    logic [AB-1:0]  a_in [NC];
    logic [NC*AB-1:0] req_addr;
    logic [NC*3-1:0]  resp_rwx;
    logic [NC*IW-1:0] resp_idx;
    assign req_addr = {a_in[1], a_in[0]};

    pmp_multi #(.ADDR_BITS(AB), .TBL_SIZE(TS), .NCH(NC)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_we(we), .i_wr_idx(wr_idx), .i_wr_cfg(wr_cfg),
        .i_wr_addr(wr_addr), .i_rd_idx(rd_idx), .o_rd_cfg(rd_cfg), .o_rd_addr(rd_addr),
        .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_m(req_m),
        .o_resp_valid(resp_valid), .o_resp_rwx(resp_rwx), .o_resp_hit(resp_hit),
        .o_resp_idx(resp_idx)
    );

    // Reference model state
    logic [7:0]    m_cfg  [TS];
    logic [AW-1:0] m_addr [TS];
    bit            e_vld [NC];
    bit            e_hit [NC];
    logic [IW-1:0] e_idx [NC];
    logic [2:0]    e_rwx [NC];
    int checks = 0, failures = 0;

    task automatic model_reset();
        for (int i = 0; i < TS; i++) begin m_cfg[i] = 8'h00; m_addr[i] = '0; end
        for (int c = 0; c < NC; c++) begin e_vld[c] = 0; e_hit[c] = 0; e_idx[c] = '0; e_rwx[c] = 3'b000; end
    endtask

    function automatic bit m_match(int i, longint unsigned a);
        longint unsigned lo, hi, base, size;
        int k;
        case (m_cfg[i][4:3])
            2'd1: begin
                lo = (i == 0) ? 64'd0 : 64'(m_addr[i-1]) * 4;
                hi = 64'(m_addr[i]) * 4;
                return (a >= lo) && (a < hi);
            end
            2'd2: return (a / 4) == 64'(m_addr[i]);
            2'd3: begin
                k = 0;
                while (k < AW && m_addr[i][k]) k++;
                size = 64'd1 << (k + 3);
                base = ((64'(m_addr[i]) >> (k + 1)) << (k + 1)) * 4;
                return (a >= base) && (a < base + size);
            end
            default: return 0;
        endcase
    endfunction

    // Predict this edge's responses from the current table, apply any write, advance one clock.
    task automatic tick();
        logic [7:0] c8;
        for (int c = 0; c < NC; c++) begin
            e_vld[c] = req_valid[c];
            if (req_valid[c]) begin
                e_hit[c] = 0; e_idx[c] = '0; e_rwx[c] = req_m[c] ? 3'b111 : 3'b000;
                for (int i = 0; i < TS; i++) begin
                    if (m_match(i, 64'(a_in[c]))) begin
                        e_hit[c] = 1; e_idx[c] = IW'(i);
                        e_rwx[c] = (req_m[c] && !m_cfg[i][7]) ? 3'b111 : {m_cfg[i][0], m_cfg[i][1], m_cfg[i][2]};
                        break;
                    end
                end
            end
        end
        if (we && !m_cfg[wr_idx][7]) begin
            c8 = wr_cfg; c8[6:5] = 2'b00;
            if (c8[1] && !c8[0]) c8[1] = 1'b0;
            if (!(int'(wr_idx) < TS - 1 && m_cfg[wr_idx+1][7] && m_cfg[wr_idx+1][4:3] == 2'd1))
                m_addr[wr_idx] = wr_addr;
            m_cfg[wr_idx] = c8;
        end
        @(posedge clk); #1;
    endtask

    task automatic wr(input int idx, input logic [7:0] cfg, input logic [AW-1:0] addr);
        we = 1'b1; wr_idx = IW'(idx); wr_cfg = cfg; wr_addr = addr; req_valid = '0;
        tick();
        we = 1'b0;
    endtask

    function automatic logic [8:0] obs(int c);
        return {resp_valid[c], resp_hit[c], resp_idx[c*IW +: IW], resp_rwx[c*3 +: 3]};
    endfunction
    function automatic logic [8:0] expv(int c);
        return {e_vld[c], e_hit[c], e_idx[c], e_rwx[c]};
    endfunction

    task automatic test_reset();
        model_reset();
        #12;
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (obs(c) !== 9'd0) begin failures++; $display("FAIL reset_out ch%0d got=%h exp=%h", c, obs(c), 9'd0); end
        end
        for (int i = 0; i < TS; i += 5) begin
            rd_idx = IW'(i); #1;
            checks++;
            if (rd_cfg !== 8'h00 || rd_addr !== '0) begin failures++; $display("FAIL reset_rd e%0d got=%h/%h exp=0", i, rd_cfg, rd_addr); end
        end
        @(negedge clk); nrst = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b11; req_m = 2'b01;
        a_in[0] = AB'({$urandom, $urandom}); a_in[1] = AB'({$urandom, $urandom});
        tick();
        req_valid = '0;
        checks++;
        if (obs(0) !== {1'b1, 1'b0, 4'd0, 3'b111}) begin failures++; $display("FAIL first_req_m got=%h exp=%h", obs(0), {1'b1, 1'b0, 4'd0, 3'b111}); end
        checks++;
        if (obs(1) !== {1'b1, 1'b0, 4'd0, 3'b000}) begin failures++; $display("FAIL first_req_u got=%h exp=%h", obs(1), {1'b1, 1'b0, 4'd0, 3'b000}); end
    endtask

    task automatic test_napot();
        logic [AB-1:0] ta [4];
        logic [8:0]    te [4];
        ta = '{48'h2000_0000, 48'h2000_0400, 48'h2000_03FF, 48'h1FFF_FFFF};
        te = '{{2'b11, 4'd0, 3'b110}, {2'b10, 4'd0, 3'b000}, {2'b11, 4'd0, 3'b110}, {2'b10, 4'd0, 3'b000}};
        wr(0, 8'h1B, 46'h0800_007F);
        for (int n = 0; n < 4; n++) begin
            req_valid = 2'b01; req_m = 2'b00; a_in[0] = ta[n];
            tick();
            checks++;
            if (obs(0) !== te[n]) begin failures++; $display("FAIL napot a=%h got=%h exp=%h", ta[n], obs(0), te[n]); end
            checks++;
            if (obs(1) !== expv(1)) begin failures++; $display("FAIL napot_idle ch1 got=%h exp=%h", obs(1), expv(1)); end
        end
        req_valid = '0;
    endtask

    task automatic test_priority();
        logic [AB-1:0] ta [6];
        logic [8:0]    te [6];
        ta = '{48'h1800, 48'h3000, 48'h1000, 48'h1FFF, 48'h0FFF, 48'h2000};
        te = '{{2'b11, 4'd1, 3'b001}, {2'b11, 4'd2, 3'b111}, {2'b11, 4'd1, 3'b001},
               {2'b11, 4'd1, 3'b001}, {2'b11, 4'd2, 3'b111}, {2'b11, 4'd2, 3'b111}};
        wr(0, 8'h00, 46'h400);
        wr(1, 8'h0C, 46'h800);
        wr(2, 8'h1F, '1);
        for (int n = 0; n < 6; n += 2) begin
            req_valid = 2'b11; req_m = 2'b00; a_in[0] = ta[n]; a_in[1] = ta[n+1];
            tick();
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (obs(c) !== te[n+c]) begin failures++; $display("FAIL prio a=%h got=%h exp=%h", ta[n+c], obs(c), te[n+c]); end
            end
        end
        req_valid = 2'b01; req_m = 2'b01; a_in[0] = 48'h1800;
        tick();
        checks++;
        if (obs(0) !== {2'b11, 4'd1, 3'b111}) begin failures++; $display("FAIL prio_m_unlocked got=%h exp=%h", obs(0), {2'b11, 4'd1, 3'b111}); end
        req_valid = '0;
    endtask

    task automatic test_lock();
        wr(2, 8'h1F, 46'hC00);
        wr(3, 8'h89, 46'h1000);
        wr(3, 8'h00, 46'h0);
        wr(2, 8'h1F, 46'h5555);
        rd_idx = 4'd3; #1;
        checks++;
        if (rd_cfg !== 8'h89 || rd_addr !== 46'h1000) begin failures++; $display("FAIL lock_rd3 got=%h/%h exp=89/1000", rd_cfg, rd_addr); end
        rd_idx = 4'd2; #1;
        checks++;
        if (rd_cfg !== 8'h1F || rd_addr !== 46'hC00) begin failures++; $display("FAIL lock_rd2 got=%h/%h exp=1f/c00", rd_cfg, rd_addr); end
        req_valid = 2'b11; req_m = 2'b01; a_in[0] = 48'h3800; a_in[1] = 48'h3004;
        tick();
        req_valid = '0;
        checks++;
        if (obs(0) !== {2'b11, 4'd3, 3'b100}) begin failures++; $display("FAIL lock_m got=%h exp=%h", obs(0), {2'b11, 4'd3, 3'b100}); end
        checks++;
        if (obs(1) !== {2'b11, 4'd2, 3'b111}) begin failures++; $display("FAIL lock_napot8 got=%h exp=%h", obs(1), {2'b11, 4'd2, 3'b111}); end
        wr(4, 8'h62, 46'h7);
        rd_idx = 4'd4; #1;
        checks++;
        if (rd_cfg !== 8'h00) begin failures++; $display("FAIL legal_cfg62 got=%h exp=00", rd_cfg); end
        wr(4, 8'h67, 46'h7);
        #1;
        checks++;
        if (rd_cfg !== 8'h07 || rd_addr !== 46'h7) begin failures++; $display("FAIL legal_cfg67 got=%h/%h exp=07/7", rd_cfg, rd_addr); end
    endtask

    task automatic test_back_to_back();
        int cnt [NC];
        logic [2:0] want;
        cnt = '{0, 0};
        wr(5, 8'h19, 46'h2000_01FF);
        for (int n = 1; n <= 8; n++) begin
            req_valid = 2'b11; req_m = 2'b00;
            for (int c = 0; c < NC; c++) a_in[c] = 48'h8000_0000 + AB'($urandom_range(0, 4095));
            if (n == 4) begin we = 1'b1; wr_idx = 4'd5; wr_cfg = 8'h1F; wr_addr = 46'h2000_01FF; end
            tick();
            we = 1'b0;
            want = (n <= 4) ? 3'b100 : 3'b111;
            for (int c = 0; c < NC; c++) begin
                cnt[c] += int'(resp_valid[c]);
                checks++;
                if (obs(c) !== {2'b11, 4'd5, want} || obs(c) !== expv(c))
                    begin failures++; $display("FAIL b2b cyc%0d ch%0d got=%h exp=%h", n, c, obs(c), {2'b11, 4'd5, want}); end
            end
        end
        req_valid = '0;
        tick();
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (obs(c) !== {2'b01, 4'd5, 3'b111}) begin failures++; $display("FAIL b2b_hold ch%0d got=%h exp=%h", c, obs(c), {2'b01, 4'd5, 3'b111}); end
            checks++;
            if (cnt[c] != 8) begin failures++; $display("FAIL b2b_pulses ch%0d got=%0d exp=8", c, cnt[c]); end
        end
    endtask

    task automatic test_random();
        int k, j;
        for (int n = 0; n < 400; n++) begin
            we = ($urandom_range(0, 3) == 0);
            wr_idx = IW'($urandom_range(0, TS - 1));
            wr_cfg = 8'($urandom);
            if ($urandom_range(0, 15) != 0) wr_cfg[7] = 1'b0;
            k = $urandom_range(0, 12);
            wr_addr = (46'($urandom_range(0, 'h3FFF)) << k) | ((46'd1 << k) - 46'd1);
            if ($urandom_range(0, 31) == 0) wr_addr = '1;
            for (int c = 0; c < NC; c++) begin
                req_valid[c] = ($urandom_range(0, 3) != 0);
                req_m[c] = 1'($urandom);
                j = $urandom_range(0, TS - 1);
                a_in[c] = AB'(64'(m_addr[j]) * 4) + AB'($urandom_range(0, 31)) - AB'(16);
                if ($urandom_range(0, 7) == 0) a_in[c] = AB'({$urandom, $urandom});
            end
            rd_idx = IW'($urandom_range(0, TS - 1));
            tick();
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (obs(c) !== expv(c)) begin failures++; $display("FAIL rand n%0d ch%0d got=%h exp=%h", n, c, obs(c), expv(c)); end
            end
            checks++;
            if (rd_cfg !== m_cfg[rd_idx] || rd_addr !== m_addr[rd_idx])
                begin failures++; $display("FAIL rand_rd n%0d e%0d got=%h/%h exp=%h/%h", n, rd_idx, rd_cfg, rd_addr, m_cfg[rd_idx], m_addr[rd_idx]); end
        end
        we = 1'b0; req_valid = '0;
    endtask

    task automatic test_reset_midstream();
        req_valid = 2'b11; req_m = 2'b00; a_in[0] = 48'h3004; a_in[1] = 48'h8000_0010;
        tick();
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (obs(c) !== expv(c)) begin failures++; $display("FAIL pre_rst ch%0d got=%h exp=%h", c, obs(c), expv(c)); end
        end
        #2; nrst = 1'b0; #1;
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (obs(c) !== 9'd0) begin failures++; $display("FAIL mid_rst ch%0d got=%h exp=%h", c, obs(c), 9'd0); end
        end
        model_reset();
        req_valid = '0;
        for (int i = 0; i < TS; i++) begin
            rd_idx = IW'(i); #1;
            checks++;
            if (rd_cfg !== 8'h00 || rd_addr !== '0) begin failures++; $display("FAIL mid_rst_rd e%0d got=%h/%h exp=0", i, rd_cfg, rd_addr); end
        end
        @(negedge clk); nrst = 1'b1;
        @(posedge clk); #1;
        tick();
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (obs(c) !== 9'd0) begin failures++; $display("FAIL post_rst_idle ch%0d got=%h exp=%h", c, obs(c), 9'd0); end
        end
        req_valid = 2'b01; req_m = 2'b01; a_in[0] = 48'h3800;
        tick();
        req_valid = '0;
        checks++;
        if (obs(0) !== {2'b10, 4'd0, 3'b111} || obs(0) !== expv(0))
            begin failures++; $display("FAIL post_rst_req got=%h exp=%h", obs(0), {2'b10, 4'd0, 3'b111}); end
    endtask

    initial begin
        we = 1'b0; wr_idx = '0; wr_cfg = '0; wr_addr = '0; rd_idx = '0;
        req_valid = '0; req_m = '0; a_in[0] = '0; a_in[1] = '0;
        test_reset();
        test_napot();
        test_priority();
        test_lock();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
